// File: rtl/dms_frame_decoder_if.sv
// Signal bundle for the DMS frame decoder: serial line and mode in,
// decoded word, payload and status flags out.
interface dms_frame_decoder_if #(
    parameter int KEY_W   = 32,
    parameter int MSG_MAX = 32
);
    localparam int LEN_W = $clog2(MSG_MAX) + 1;

    logic               str;
    logic               mode;
    logic [KEY_W-1:0]   msg;
    logic               msg_valid;
    logic               frame;
    logic [MSG_MAX-1:0] sent;
    logic [LEN_W-1:0]   sent_len;
    logic               configured;
    logic               cfg_err;
    logic               bit_err;

    modport master (
        output str, mode,
        input  msg, msg_valid, frame, sent, sent_len, configured, cfg_err, bit_err
    );

    modport slave (
        input  str, mode,
        output msg, msg_valid, frame, sent, sent_len, configured, cfg_err, bit_err
    );
endinterface

// File: rtl/dms_frame_decoder.sv
// Serial key/mask loader plus pulse-width bit demodulator that emits the
// decrypted word for every decoded bit and keeps a payload shadow register.
module dms_frame_decoder #(
    parameter int KEY_W      = 32,
    parameter int MIN_PERIOD = 10,
    parameter int MAX_PERIOD = 60,
    parameter int MSG_MAX    = 32,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    dms_frame_decoder_if.slave bus
);
    localparam int LEN_W = $clog2(MSG_MAX) + 1;
    localparam int IDX_W = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
    localparam int CFG_W = 16;
    localparam logic [4:0]       LOG_KEY   = 5'($clog2(KEY_W));
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT_P = CNT_W'(MAX_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [LEN_W-1:0] SENT_CAP  = LEN_W'(MSG_MAX);

    typedef enum logic [2:0] {CFG_HDR, CFG_KEY, CFG_CAPS, CFG_DONE, CFG_ERR} cfg_state_t;
    typedef enum logic {DEC_IDLE, DEC_BIT} dec_state_t;

    cfg_state_t         r_cfgState, w_cfgNext, w_cfgCur;
    logic [CFG_W-1:0]   r_cfgCnt, w_cfgCntCur;
    logic [2:0]         r_n;
    logic [CFG_W-1:0]   r_len;
    logic [KEY_W-1:0]   r_d, r_caps, r_maskL;
    logic               r_configured, r_cfgErr;
    logic               r_prevMode, r_prevStr;

    dec_state_t         r_decState, w_decNext;
    logic [CNT_W-1:0]   r_period, r_ones, r_zeros;
    logic               r_frame;
    logic [KEY_W-1:0]   r_msg;
    logic               r_msgValid, r_bitErr;
    logic [MSG_MAX-1:0] r_sent;
    logic [LEN_W-1:0]   r_sentLen;

    logic               w_modeRise, w_hdrLast, w_hdrBad, w_fieldLast;
    logic [3:0]         w_nibble;
    logic [CFG_W-1:0]   w_lenNew;
    logic               w_decEn, w_boundary, w_symEnd, w_shortSym, w_timeout, w_bitVal;
    logic [CNT_W-1:0]   w_periodInc;
    logic [KEY_W-1:0]   w_word;

    // A rising mode edge restarts configuration with this very sample as header bit 0.
    assign w_modeRise  = bus.mode & ~r_prevMode;
    assign w_cfgCur    = w_modeRise ? CFG_HDR : r_cfgState;
    assign w_cfgCntCur = w_modeRise ? '0 : r_cfgCnt;
    assign w_nibble    = {r_n, bus.str};
    assign w_hdrLast   = (w_cfgCur == CFG_HDR) && (w_cfgCntCur == CFG_W'(3));
    assign w_hdrBad    = {1'b0, w_nibble} > LOG_KEY;
    assign w_lenNew    = CFG_W'(1) << w_nibble;
    assign w_fieldLast = (w_cfgCntCur == r_len - CFG_W'(1));

    always_comb begin
        w_cfgNext = r_cfgState;
        if (bus.mode) begin
            w_cfgNext = w_cfgCur;
            case (w_cfgCur)
                CFG_HDR:  if (w_hdrLast) w_cfgNext = w_hdrBad ? CFG_ERR : CFG_KEY;
                CFG_KEY:  if (w_fieldLast) w_cfgNext = CFG_CAPS;
                CFG_CAPS: if (w_fieldLast) w_cfgNext = CFG_DONE;
                default:  w_cfgNext = w_cfgCur;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfgState <= CFG_HDR;
        end else begin
            r_cfgState <= w_cfgNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfgCnt     <= '0;
            r_n          <= '0;
            r_len        <= '0;
            r_d          <= '0;
            r_caps       <= '0;
            r_maskL      <= '0;
            r_configured <= 1'b0;
            r_cfgErr     <= 1'b0;
            r_prevMode   <= 1'b0;
        end else begin
            r_prevMode <= bus.mode;
            if (bus.mode) begin
                if (w_modeRise) begin
                    r_configured <= 1'b0;
                    r_cfgErr     <= 1'b0;
                end
                case (w_cfgCur)
                    CFG_HDR: begin
                        r_n <= w_nibble[2:0];
                        if (w_hdrLast) begin
                            r_cfgCnt <= '0;
                            r_len    <= w_lenNew;
                            r_d      <= '0;
                            r_caps   <= '0;
                            r_maskL  <= ~({KEY_W{1'b1}} << w_lenNew);
                            r_cfgErr <= w_hdrBad;
                        end else begin
                            r_cfgCnt <= w_cfgCntCur + CFG_W'(1);
                        end
                    end
                    CFG_KEY: begin
                        r_d      <= {r_d[KEY_W-2:0], bus.str};
                        r_cfgCnt <= w_fieldLast ? '0 : w_cfgCntCur + CFG_W'(1);
                    end
                    CFG_CAPS: begin
                        r_caps   <= {r_caps[KEY_W-2:0], bus.str};
                        r_cfgCnt <= w_fieldLast ? '0 : w_cfgCntCur + CFG_W'(1);
                        if (w_fieldLast) r_configured <= 1'b1;
                    end
                    default: r_cfgCnt <= w_cfgCntCur;
                endcase
            end
        end
    end

    assign w_decEn     = ~bus.mode & r_configured;
    assign w_boundary  = ~r_prevStr & bus.str;
    assign w_periodInc = (r_period == CNT_SAT) ? r_period : r_period + CNT_W'(1);
    assign w_shortSym  = w_symEnd && (r_period < MIN_P);
    assign w_bitVal    = r_ones > r_zeros;
    assign w_word      = w_bitVal ? ((~r_d | r_caps) & r_maskL) : ((r_d | r_caps) & r_maskL);

    always_comb begin
        w_decNext = r_decState;
        w_symEnd  = 1'b0;
        w_timeout = 1'b0;
        if (!w_decEn) begin
            w_decNext = DEC_IDLE;
        end else begin
            case (r_decState)
                DEC_IDLE: if (w_boundary) w_decNext = DEC_BIT;
                DEC_BIT: begin
                    if (w_boundary) begin
                        w_symEnd = 1'b1;
                    end else if (w_periodInc >= TIMEOUT_P) begin
                        w_timeout = 1'b1;
                        w_decNext = DEC_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decState <= DEC_IDLE;
        end else begin
            r_decState <= w_decNext;
        end
    end

    // r_frame doubles as "symbol index is non-zero": the next symbol end after it drops is a sync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prevStr  <= 1'b0;
            r_period   <= '0;
            r_ones     <= '0;
            r_zeros    <= '0;
            r_frame    <= 1'b0;
            r_msg      <= '0;
            r_msgValid <= 1'b0;
            r_bitErr   <= 1'b0;
            r_sent     <= '0;
            r_sentLen  <= '0;
        end else begin
            r_prevStr  <= bus.str;
            r_msgValid <= 1'b0;
            r_bitErr   <= 1'b0;
            if (!w_decEn) begin
                r_frame <= 1'b0;
            end else if (r_decState == DEC_IDLE) begin
                if (w_boundary) begin
                    r_period <= '0;
                    r_ones   <= '0;
                    r_zeros  <= '0;
                end
            end else if (w_symEnd) begin
                r_period <= CNT_W'(1);
                r_ones   <= CNT_W'(1);
                r_zeros  <= '0;
                if (w_shortSym) begin
                    r_bitErr <= 1'b1;
                    r_frame  <= 1'b0;
                end else if (!r_frame) begin
                    r_frame   <= 1'b1;
                    r_sent    <= '0;
                    r_sentLen <= '0;
                end else begin
                    r_msg      <= w_word;
                    r_msgValid <= 1'b1;
                    if (r_sentLen < SENT_CAP) begin
                        r_sent[r_sentLen[IDX_W-1:0]] <= w_bitVal;
                        r_sentLen <= r_sentLen + LEN_W'(1);
                    end
                end
            end else begin
                r_period <= w_periodInc;
                if (bus.str && r_ones != CNT_SAT) r_ones <= r_ones + CNT_W'(1);
                if (!bus.str && r_zeros != CNT_SAT) r_zeros <= r_zeros + CNT_W'(1);
                if (w_timeout) r_frame <= 1'b0;
            end
        end
    end

    assign bus.msg        = r_msg;
    assign bus.msg_valid  = r_msgValid;
    assign bus.frame      = r_frame;
    assign bus.sent       = r_sent;
    assign bus.sent_len   = r_sentLen;
    assign bus.configured = r_configured;
    assign bus.cfg_err    = r_cfgErr;
    assign bus.bit_err    = r_bitErr;
endmodule

// File: tb/tb_dms_frame_decoder.sv
// Scoreboard bench for dms_frame_decoder: expected words are queued as bit
// symbols are driven and popped whenever the decoder strobes msg_valid.
module tb_dms_frame_decoder;
    localparam int KEY_W   = 32;
    localparam int MSG_MAX = 32;

    typedef struct {
        logic [31:0] msg;
        int          len;
        logic        bitVal;
        logic        stored;
    } exp_t;

    logic clk;
    logic reset;
    int   totalChecks = 0;
    int   badChecks   = 0;

    exp_t        sbQ[$];
    logic [31:0] tbD, tbCaps, tbMask;
    logic [31:0] tbSent;
    int          tbLen;

    dms_frame_decoder_if #(.KEY_W(KEY_W), .MSG_MAX(MSG_MAX)) bus ();

    dms_frame_decoder #(
        .KEY_W(KEY_W), .MIN_PERIOD(10), .MAX_PERIOD(60), .MSG_MAX(MSG_MAX), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic m);
        bus.str  = s;
        bus.mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(s, 1'b0);
    endtask

    task automatic sendSym(input int high, input int total);
        drive(1'b1, high);
        drive(1'b0, total - high);
    endtask

    task automatic pushExp(input logic b);
        exp_t e;
        e.msg    = b ? ((~tbD | tbCaps) & tbMask) : ((tbD | tbCaps) & tbMask);
        e.bitVal = b;
        e.stored = 1'b0;
        if (tbLen < MSG_MAX) begin
            tbSent[tbLen] = b;
            tbLen++;
            e.stored = 1'b1;
        end
        e.len = tbLen;
        sbQ.push_back(e);
    endtask

    task automatic sendBit(input logic b, input int total);
        pushExp(b);
        sendSym(b ? (total * 2) / 3 : total / 3, total);
    endtask

    task automatic configure(input logic [3:0] n, input logic [31:0] d, input logic [31:0] caps);
        int L;
        L = 1 << n;
        for (int i = 3; i >= 0; i--) applyStimulus(n[i], 1'b1);
        for (int i = L - 1; i >= 0; i--) applyStimulus(d[i], 1'b1);
        for (int i = L - 1; i > 0; i--) applyStimulus(caps[i], 1'b1);
        checkOutput("cfgNotYet", 64'(bus.configured), 64'd0);
        applyStimulus(caps[0], 1'b1);
        checkOutput("configured", 64'(bus.configured), 64'd1);
        checkOutput("cfgErrClear", 64'(bus.cfg_err), 64'd0);
        tbMask = 32'((64'd1 << L) - 64'd1);
        tbD    = d & tbMask;
        tbCaps = caps & tbMask;
    endtask

    always @(negedge clk) begin
        if (bus.msg_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("spuriousValid", 64'(bus.msg_valid), 64'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("msg", 64'(bus.msg), 64'(e.msg));
                checkOutput("sentLen", 64'(bus.sent_len), 64'(e.len));
                if (e.stored) checkOutput("sentBit", 64'(bus.sent[e.len - 1]), 64'(e.bitVal));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        bus.str  = 1'b0;
        bus.mode = 1'b0;
        tbLen    = 0;
        tbSent   = '0;
        tbD      = '0;
        tbCaps   = '0;
        tbMask   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstFlags", 64'({bus.frame, bus.msg_valid, bus.configured, bus.cfg_err, bus.bit_err}), 64'd0);
        checkOutput("rstMsg", 64'(bus.msg), 64'd0);
        checkOutput("rstSent", 64'(bus.sent), 64'd0);
        checkOutput("rstSentLen", 64'(bus.sent_len), 64'd0);
        reset = 1'b0;

        // Basic frame with the 4-bit key: d=1010, caps=0001.
        configure(4'd2, 32'hA, 32'h1);
        drive(1'b0, 3);
        sendSym(6, 12);
        tbLen = 0; tbSent = '0;
        sendBit(1'b1, 12);
        checkOutput("frameUp", 64'(bus.frame), 64'd1);
        sendBit(1'b0, 12);
        sendSym(3, 6);
        checkOutput("sentAfterTwo", 64'(bus.sent), 64'h1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("bitErrPulse", 64'(bus.bit_err), 64'd1);
        checkOutput("frameDropShort", 64'(bus.frame), 64'd0);
        checkOutput("msgHoldShort", 64'(bus.msg), 64'hB);
        drive(1'b1, 5);
        checkOutput("bitErrOneCycle", 64'(bus.bit_err), 64'd0);
        drive(1'b0, 6);

        // Resync frame, then time out after the second bit.
        tbLen = 0; tbSent = '0;
        sendBit(1'b0, 12);
        checkOutput("frameResync", 64'(bus.frame), 64'd1);
        checkOutput("sentLenCleared", 64'(bus.sent_len), 64'd0);
        sendBit(1'b1, 12);
        applyStimulus(1'b1, 1'b0);
        drive(1'b0, 59);
        checkOutput("frameBeforeTimeout", 64'(bus.frame), 64'd1);
        drive(1'b0, 1);
        checkOutput("frameTimeout", 64'(bus.frame), 64'd0);
        checkOutput("sentLenHold", 64'(bus.sent_len), 64'd2);
        checkOutput("sentHold", 64'(bus.sent), 64'h2);
        checkOutput("msgHoldTimeout", 64'(bus.msg), 64'h5);
        sendSym(6, 12);
        tbLen = 0; tbSent = '0;
        sendBit(1'b1, 12);
        checkOutput("frameAfterTimeout", 64'(bus.frame), 64'd1);
        checkOutput("sentLenNewSync", 64'(bus.sent_len), 64'd0);
        applyStimulus(1'b1, 1'b0);

        // Full-width key, tie symbol, minimum-length symbols and payload saturation.
        configure(4'd5, $urandom, $urandom);
        checkOutput("frameModeRise", 64'(bus.frame), 64'd0);
        drive(1'b0, 3);
        sendSym(6, 12);
        tbLen = 0; tbSent = '0;
        pushExp(1'b0);
        sendSym(6, 12);
        for (int i = 0; i < 33; i++) sendBit(1'($urandom_range(0, 1)), (i % 2 == 1) ? 10 : 12);
        applyStimulus(1'b1, 1'b0);
        drive(1'b0, 2);
        checkOutput("sentLenSat", 64'(bus.sent_len), 64'd32);
        checkOutput("sentSat", 64'(bus.sent), 64'(tbSent));
        checkOutput("frameStillUp", 64'(bus.frame), 64'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("frameModeDecode", 64'(bus.frame), 64'd0);
        checkOutput("cfgClearedByMode", 64'(bus.configured), 64'd0);
        drive(1'b0, 2);

        // Oversized header: L=64 exceeds the 32-bit key.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cfgErrNotYet", 64'(bus.cfg_err), 64'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("cfgErrSet", 64'(bus.cfg_err), 64'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'(i % 2), 1'b1);
        checkOutput("cfgErrHold", 64'(bus.cfg_err), 64'd1);
        checkOutput("cfgErrNotConfigured", 64'(bus.configured), 64'd0);
        drive(1'b0, 2);
        sendSym(6, 12);
        sendSym(8, 12);
        applyStimulus(1'b1, 1'b0);
        checkOutput("frameUnconfigured", 64'(bus.frame), 64'd0);

        // Asynchronous reset in the middle of a frame.
        drive(1'b0, 2);
        configure(4'd2, 32'hA, 32'h1);
        drive(1'b0, 3);
        sendSym(6, 12);
        sendSym(8, 12);
        checkOutput("frameBeforeReset", 64'(bus.frame), 64'd1);
        #3 reset = 1'b1;
        #1;
        checkOutput("asyncRstFlags", 64'({bus.frame, bus.msg_valid, bus.configured, bus.cfg_err, bus.bit_err}), 64'd0);
        checkOutput("asyncRstMsg", 64'(bus.msg), 64'd0);
        checkOutput("asyncRstLen", 64'(bus.sent_len), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendSym(6, 12);
        sendSym(8, 12);
        sendSym(4, 12);
        applyStimulus(1'b1, 1'b0);
        checkOutput("frameAfterReset", 64'(bus.frame), 64'd0);
        checkOutput("cfgAfterReset", 64'(bus.configured), 64'd0);
        drive(1'b0, 2);

        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
